switch_debounce_counter: RTL and testbench

SWITCH_DEBOUNCE_COUNTER -- requirements
Module: switch_debounce_counter

---
 rtl/switch_debounce_counter.sv | 108 ++++++++++
 tb/tb_switch_debounce_counter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce_counter.sv
// Multi-channel switch debouncer with per-channel edge event counters.
// Raw inputs are synchronised, sampled on a shared prescaler tick, and filtered with hysteresis.
module switch_debounce_counter #(
    parameter int N_CH      = 4,
    parameter int CNT_W     = 4,
    parameter int TICK_DIV  = 65536,
    parameter int SHIFT_LEN = 5,
    parameter int EDGE_SEL  = 0,
    parameter int SAT       = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         sw_in,
    input  logic [N_CH-1:0]         clr,
    output logic [N_CH-1:0]         sw_level,
    output logic [N_CH-1:0]         rise_pulse,
    output logic [N_CH-1:0]         fall_pulse,
    output logic [N_CH*CNT_W-1:0]   count,
    output logic [N_CH-1:0]         wrap
);

    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0]   r_presc;
    logic            w_tick;
    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;

    assign w_tick = (r_presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            r_sync1 <= sw_in;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [SHIFT_LEN-1:0] r_hist;
        logic [SHIFT_LEN-1:0] w_hist_next;
        logic                 r_level;
        logic                 r_rise;
        logic                 r_fall;
        logic                 r_wrap;
        logic [CNT_W-1:0]     r_cnt;
        logic [CNT_W-1:0]     w_cnt_inc;
        logic                 w_rise;
        logic                 w_fall;
        logic                 w_event;
        logic                 w_max;

        // The level decision looks at the history as it will be after this tick's shift.
        assign w_hist_next = {r_hist[SHIFT_LEN-2:0], r_sync2[gi]};
        assign w_rise      = w_tick & ~r_level & (&w_hist_next);
        assign w_fall      = w_tick &  r_level & ~(|w_hist_next);
        assign w_event     = (EDGE_SEL == 0) ? w_fall :
                             (EDGE_SEL == 1) ? w_rise : (w_rise | w_fall);
        assign w_cnt_inc   = r_cnt + 1'b1;
        assign w_max       = &r_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_hist  <= '0;
                r_level <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
                r_wrap  <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_rise <= w_rise;
                r_fall <= w_fall;
                r_wrap <= 1'b0;
                if (w_tick) begin
                    r_hist <= w_hist_next;
                end
                if (w_rise) begin
                    r_level <= 1'b1;
                end else if (w_fall) begin
                    r_level <= 1'b0;
                end
                // Clear wins over a coincident event; that event is dropped.
                if (clr[gi]) begin
                    r_cnt <= '0;
                end else if (w_event) begin
                    if (SAT == 0) begin
                        r_cnt  <= w_cnt_inc;
                        r_wrap <= w_max;
                    end else if (!w_max) begin
                        r_cnt  <= w_cnt_inc;
                        r_wrap <= &w_cnt_inc;
                    end
                end
            end
        end

        assign sw_level[gi]                 = r_level;
        assign rise_pulse[gi]               = r_rise;
        assign fall_pulse[gi]               = r_fall;
        assign wrap[gi]                     = r_wrap;
        assign count[gi*CNT_W +: CNT_W]     = r_cnt;
    end

endmodule

// File: tb/tb_switch_debounce_counter.sv
// Bench for switch_debounce_counter: four parameter variants share stimulus and are
// compared every cycle against a run-length based behavioural model.
module tb_switch_debounce_counter;

    localparam int N_CH  = 2;
    localparam int CNT_W = 4;
    localparam int TD    = 4;
    localparam int SL    = 5;
    localparam int NI    = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic [N_CH-1:0] sw_in;
    logic [N_CH-1:0] clr;

    logic [NI-1:0][N_CH-1:0]       lvl;
    logic [NI-1:0][N_CH-1:0]       rp;
    logic [NI-1:0][N_CH-1:0]       fp;
    logic [NI-1:0][N_CH-1:0]       wr;
    logic [NI-1:0][N_CH*CNT_W-1:0] cnt;

    always #5 clk = ~clk;

    // Variants: 0 fall/wrap, 1 rise/sat, 2 both/wrap, 3 fall/sat
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        switch_debounce_counter #(
            .N_CH      (N_CH),
            .CNT_W     (CNT_W),
            .TICK_DIV  (TD),
            .SHIFT_LEN (SL),
            .EDGE_SEL  ((gi == 1) ? 1 : ((gi == 2) ? 2 : 0)),
            .SAT       ((gi == 1 || gi == 3) ? 1 : 0)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .sw_in      (sw_in),
            .clr        (clr),
            .sw_level   (lvl[gi]),
            .rise_pulse (rp[gi]),
            .fall_pulse (fp[gi]),
            .count      (cnt[gi]),
            .wrap       (wr[gi])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    int              m_cyc;
    bit [N_CH-1:0]   m_s1, m_s2;
    int              m_run_val [N_CH];
    int              m_run_len [N_CH];
    bit [N_CH-1:0]   m_lvl, m_rise, m_fall;
    int              m_cnt [NI][N_CH];
    bit [N_CH-1:0]   m_wrap [NI];

    function automatic int es_of(int k);
        return (k == 1) ? 1 : ((k == 2) ? 2 : 0);
    endfunction

    function automatic bit sat_of(int k);
        return (k == 1 || k == 3);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Behaviour at one rising edge, using the inputs present at that edge.
    task automatic model_edge();
        bit          tick;
        bit [N_CH-1:0] smp;
        bit          ev;
        if (rst) begin
            m_cyc = 0; m_s1 = '0; m_s2 = '0;
            m_lvl = '0; m_rise = '0; m_fall = '0;
            for (int ch = 0; ch < N_CH; ch++) begin
                m_run_val[ch] = 0;
                m_run_len[ch] = 0;
            end
            for (int k = 0; k < NI; k++) begin
                m_wrap[k] = '0;
                for (int ch = 0; ch < N_CH; ch++) m_cnt[k][ch] = 0;
            end
        end else begin
            tick  = ((m_cyc % TD) == TD - 1);
            m_cyc++;
            smp   = m_s2;
            m_s2  = m_s1;
            m_s1  = sw_in;
            m_rise = '0;
            m_fall = '0;
            for (int k = 0; k < NI; k++) m_wrap[k] = '0;
            if (tick) begin
                for (int ch = 0; ch < N_CH; ch++) begin
                    if (m_run_len[ch] > 0 && m_run_val[ch] == int'(smp[ch])) begin
                        m_run_len[ch]++;
                    end else begin
                        m_run_val[ch] = int'(smp[ch]);
                        m_run_len[ch] = 1;
                    end
                    if (m_run_len[ch] >= SL && m_run_val[ch] != int'(m_lvl[ch])) begin
                        if (smp[ch]) m_rise[ch] = 1'b1;
                        else         m_fall[ch] = 1'b1;
                        m_lvl[ch] = smp[ch];
                    end
                end
            end
            for (int k = 0; k < NI; k++) begin
                for (int ch = 0; ch < N_CH; ch++) begin
                    case (es_of(k))
                        0:       ev = m_fall[ch];
                        1:       ev = m_rise[ch];
                        default: ev = m_rise[ch] | m_fall[ch];
                    endcase
                    if (clr[ch]) begin
                        m_cnt[k][ch] = 0;
                    end else if (ev) begin
                        if (!sat_of(k)) begin
                            m_cnt[k][ch] = (m_cnt[k][ch] + 1) % (CMAX + 1);
                            if (m_cnt[k][ch] == 0) m_wrap[k][ch] = 1'b1;
                        end else if (m_cnt[k][ch] < CMAX) begin
                            m_cnt[k][ch]++;
                            if (m_cnt[k][ch] == CMAX) m_wrap[k][ch] = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        logic [N_CH*CNT_W-1:0] exp_cnt;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            exp_cnt = '0;
            for (int ch = 0; ch < N_CH; ch++) exp_cnt[ch*CNT_W +: CNT_W] = CNT_W'(m_cnt[k][ch]);
            check_eq($sformatf("i%0d_level", k), 32'(lvl[k]), 32'(m_lvl));
            check_eq($sformatf("i%0d_rise",  k), 32'(rp[k]),  32'(m_rise));
            check_eq($sformatf("i%0d_fall",  k), 32'(fp[k]),  32'(m_fall));
            check_eq($sformatf("i%0d_wrap",  k), 32'(wr[k]),  32'(m_wrap[k]));
            check_eq($sformatf("i%0d_count", k), 32'(cnt[k]), 32'(exp_cnt));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst = 1'b1; sw_in = '0; clr = '0;
        run(3);
        rst = 1'b0;
        run(10);

        // Bounce on ch0 every 6 cycles from a low level, then settle low.
        for (int i = 0; i < 7; i++) begin
            sw_in[0] = ~sw_in[0];
            run(6);
        end
        sw_in[0] = 1'b0;
        run(40);

        // Clean press held on ch0, then release.
        sw_in = 2'b01;
        run(40);
        sw_in = 2'b00;
        run(40);

        // Clean full cycles on both channels; enough events to wrap or saturate.
        for (int i = 0; i < 20; i++) begin
            sw_in = 2'b11; run(30);
            sw_in = 2'b00; run(30);
        end

        // Clear ch0 held across a release event: the event must be dropped.
        sw_in = 2'b11; run(30);
        clr = 2'b01; sw_in = 2'b00; run(30);
        clr = 2'b00; run(5);

        // Reset after roughly three agreeing ticks on ch0.
        sw_in = 2'b01; run(2 + 3 * TD + 1);
        rst = 1'b1; run(1);
        rst = 1'b0; run(45);
        sw_in = 2'b00; run(40);

        // Random hold lengths, sporadic clears and occasional resets.
        for (int it = 0; it < 80; it++) begin
            int hold;
            sw_in = N_CH'($urandom);
            hold  = $urandom_range(1, 36);
            for (int j = 0; j < hold; j++) begin
                clr = ($urandom_range(0, 15) == 0) ? N_CH'($urandom) : '0;
                rst = ($urandom_range(0, 200) == 0);
                cycle();
            end
            clr = '0;
            rst = 1'b0;
        end
        run(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
